// File: rtl/vrased_rst_ctrl_pkg.sv
// Shared definitions for the VRASED reset sequencer: violation bit map,
// FSM state encoding and the violation vector type.
package vrased_rst_ctrl_pkg;

  localparam int NUM_VIOL = 6;

  localparam int VIOL_XSTACK     = 0;
  localparam int VIOL_AC         = 1;
  localparam int VIOL_ATOMICITY  = 2;
  localparam int VIOL_DMA_AC     = 3;
  localparam int VIOL_DMA_DETECT = 4;
  localparam int VIOL_DMA_XSTACK = 5;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_WAIT_PC = 2'd2;

  typedef logic [NUM_VIOL-1:0] viol_t;

  function automatic logic viol_any(input viol_t v);
    return |v;
  endfunction

endpackage

// File: rtl/vrased_sat_cnt.sv
// Saturating up-counter with synchronous clear and increment enable.
module vrased_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && !(&count_q)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/vrased_rst_ctrl.sv
// Stretches VRASED monitor violations into a registered CPU reset, logs the
// cause, then waits for the CPU to refetch from the reset handler.
//
// state      | meaning
// IDLE       | no violation pending, cause log may be cleared
// HOLD       | sys_rst asserted, hold counter running down
// WAIT_PC    | reset released, waiting for pc to hit RESET_HANDLER
module vrased_rst_ctrl
  import vrased_rst_ctrl_pkg::*;
#(
  parameter int          HOLD_CYCLES   = 4,
  parameter logic [15:0] RESET_HANDLER = 16'h0000,
  parameter int          CNT_W         = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_VIOL-1:0] viol,
  input  logic [15:0]         pc,
  input  logic                clr_cause,
  output logic                sys_rst,
  output logic                busy,
  output logic [NUM_VIOL-1:0] cause,
  output logic [NUM_VIOL-1:0] first_cause,
  output logic [CNT_W-1:0]    viol_count
);

  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0] HOLD_LOAD = HC_W'(HOLD_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [HC_W-1:0]  hold_q, hold_d;
  logic             sys_rst_q, busy_q;
  viol_t            cause_q, cause_d;
  viol_t            first_q, first_d;
  logic             any_viol, new_event, clr_logs;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    any_viol  = viol_any(viol);
    state_d   = state_q;
    hold_d    = hold_q;
    new_event = 1'b0;
    clr_logs  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_viol) begin
          state_d   = ST_HOLD;
          hold_d    = HOLD_LOAD;
          new_event = 1'b1;
        end else if (clr_cause) begin
          clr_logs = 1'b1;
        end
      end
      ST_HOLD: begin
        // a violation while holding extends the reset but is the same event
        if (any_viol) begin
          hold_d = HOLD_LOAD;
        end else if (hold_q == '0) begin
          state_d = ST_WAIT_PC;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      ST_WAIT_PC: begin
        if (any_viol) begin
          state_d   = ST_HOLD;
          hold_d    = HOLD_LOAD;
          new_event = 1'b1;
        end else if (pc == RESET_HANDLER) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        hold_d  = '0;
      end
    endcase

    cause_d = clr_logs ? '0 : (cause_q | viol);

    first_d = first_q;
    if (clr_logs) begin
      first_d = '0;
    end else if (new_event && (cnt == '0)) begin
      first_d = viol;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      sys_rst_q <= 1'b0;
      busy_q    <= 1'b0;
      cause_q   <= '0;
      first_q   <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      sys_rst_q <= (state_d == ST_HOLD);
      busy_q    <= (state_d != ST_IDLE);
      cause_q   <= cause_d;
      first_q   <= first_d;
    end
  end

  vrased_sat_cnt #(
    .W(CNT_W)
  ) u_viol_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (clr_logs),
    .inc  (new_event),
    .count(cnt)
  );

  assign sys_rst     = sys_rst_q;
  assign busy        = busy_q;
  assign cause       = cause_q;
  assign first_cause = first_q;
  assign viol_count  = cnt;

endmodule

// File: tb/tb_vrased_rst_ctrl.sv
// Scoreboard bench for vrased_rst_ctrl: directed scenarios, random traffic
// against a behavioural model, and a narrow-counter instance for saturation.
module tb_vrased_rst_ctrl;

  localparam int          HOLD = 4;
  localparam logic [15:0] RH   = 16'h0000;
  localparam logic [15:0] PC_X = 16'h4400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, clr_cause, sys_rst, busy;
  logic [5:0]  viol, cause, first_cause;
  logic [15:0] pc;
  logic [7:0]  viol_count;

  logic        s_reset, s_clr, s_sys_rst, s_busy;
  logic [5:0]  s_viol, s_cause, s_first;
  logic [15:0] s_pc;
  logic [1:0]  s_count;

  vrased_rst_ctrl #(.HOLD_CYCLES(HOLD), .RESET_HANDLER(RH), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .viol(viol), .pc(pc), .clr_cause(clr_cause),
    .sys_rst(sys_rst), .busy(busy), .cause(cause), .first_cause(first_cause),
    .viol_count(viol_count)
  );

  vrased_rst_ctrl #(.HOLD_CYCLES(HOLD), .RESET_HANDLER(RH), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(s_reset), .viol(s_viol), .pc(s_pc), .clr_cause(s_clr),
    .sys_rst(s_sys_rst), .busy(s_busy), .cause(s_cause), .first_cause(s_first),
    .viol_count(s_count)
  );

  typedef struct {
    logic       sys_rst;
    logic       busy;
    logic [5:0] cause;
    logic [5:0] first;
    logic [7:0] count;
  } exp_t;

  exp_t exp_q[$];
  int   sat_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // behavioural reference: 0 idle, 1 hold, 2 wait for pc
  int         m_state = 0;
  int         m_hold  = 0;
  int         m_count = 0;
  logic [5:0] m_cause = '0;
  logic [5:0] m_first = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_event(input logic [5:0] v);
    if (m_count == 0) m_first = v;
    if (m_count < 255) m_count++;
    m_cause |= v;
    m_state = 1;
    m_hold  = HOLD - 1;
  endtask

  task automatic model_step(input logic r, input logic [5:0] v, input logic [15:0] p, input logic c);
    if (r) begin
      m_state = 0; m_hold = 0; m_count = 0; m_cause = '0; m_first = '0;
    end else begin
      case (m_state)
        0: if (v != 0) model_event(v);
           else if (c) begin m_count = 0; m_cause = '0; m_first = '0; end
        1: begin
          m_cause |= v;
          if (v != 0) m_hold = HOLD - 1;
          else if (m_hold == 0) m_state = 2;
          else m_hold--;
        end
        default: if (v != 0) model_event(v);
                 else if (p == RH) m_state = 0;
      endcase
    end
  endtask

  task automatic step(input logic r, input logic [5:0] v, input logic [15:0] p, input logic c);
    exp_t e, g;
    reset = r; viol = v; pc = p; clr_cause = c;
    model_step(r, v, p, c);
    e.sys_rst = (m_state == 1);
    e.busy    = (m_state != 0);
    e.cause   = m_cause;
    e.first   = m_first;
    e.count   = 8'(m_count);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    g = exp_q.pop_front();
    check_val("sys_rst",     32'(sys_rst),     32'(g.sys_rst));
    check_val("busy",        32'(busy),        32'(g.busy));
    check_val("cause",       32'(cause),       32'(g.cause));
    check_val("first_cause", 32'(first_cause), 32'(g.first));
    check_val("viol_count",  32'(viol_count),  32'(g.count));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int         hi;
    logic       r, c;
    logic [5:0] v;
    logic [15:0] p;

    reset = 1'b1; viol = '0; pc = PC_X; clr_cause = 1'b0;
    s_reset = 1'b1; s_viol = '0; s_pc = RH; s_clr = 1'b0;

    step(1, 0, PC_X, 0);
    step(1, 0, PC_X, 0);
    check_val("reset_sys_rst", 32'(sys_rst), 0);
    check_val("reset_busy",    32'(busy),    0);
    check_val("reset_count",   32'(viol_count), 0);

    // single-cycle event
    step(0, 6'h02, PC_X, 0);
    hi = int'(sys_rst);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, PC_X, 0);
      hi += int'(sys_rst);
    end
    check_val("s1_rst_len",   32'(hi), 4);
    check_val("s1_rst_low",   32'(sys_rst), 0);
    check_val("s1_cause",     32'(cause), 32'h02);
    check_val("s1_first",     32'(first_cause), 32'h02);
    check_val("s1_count",     32'(viol_count), 1);
    step(0, 0, RH, 0);
    check_val("s1_idle_busy", 32'(busy), 0);

    // extended hold, clear ignored during HOLD
    step(0, 0, PC_X, 1);
    check_val("s2_clr_count", 32'(viol_count), 0);
    step(0, 6'h01, PC_X, 0);
    hi = int'(sys_rst);
    step(0, 0, PC_X, 0);
    hi += int'(sys_rst);
    step(0, 6'h20, PC_X, 0);
    hi += int'(sys_rst);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, PC_X, (i == 0));
      hi += int'(sys_rst);
    end
    check_val("s2_rst_len", 32'(hi), 6);
    check_val("s2_cause",   32'(cause), 32'h21);
    check_val("s2_first",   32'(first_cause), 32'h01);
    check_val("s2_count",   32'(viol_count), 1);
    step(0, 0, RH, 0);

    // re-violation in WAIT_PC beats a simultaneous pc match
    step(0, 0, PC_X, 1);
    step(0, 6'h04, PC_X, 0);
    for (int i = 0; i < 4; i++) step(0, 0, PC_X, 0);
    check_val("s3_wait_busy", 32'(busy), 1);
    check_val("s3_wait_rst",  32'(sys_rst), 0);
    step(0, 6'h08, RH, 0);
    check_val("s3_rehold_rst", 32'(sys_rst), 1);
    check_val("s3_count",      32'(viol_count), 2);
    check_val("s3_cause",      32'(cause), 32'h0C);
    check_val("s3_first",      32'(first_cause), 32'h04);
    for (int i = 0; i < 5; i++) step(0, 0, PC_X, 0);
    step(0, 0, RH, 0);

    // clear and violation together: violation wins
    step(0, 0, PC_X, 1);
    step(0, 6'h10, PC_X, 1);
    check_val("s4_count", 32'(viol_count), 1);
    check_val("s4_cause", 32'(cause), 32'h10);
    for (int i = 0; i < 5; i++) step(0, 0, PC_X, 0);
    step(0, 0, RH, 0);

    // reset on the second HOLD cycle
    step(0, 6'h01, PC_X, 0);
    step(1, 0, PC_X, 0);
    check_val("s5_rst",   32'(sys_rst), 0);
    check_val("s5_busy",  32'(busy), 0);
    check_val("s5_cause", 32'(cause), 0);
    check_val("s5_first", 32'(first_cause), 0);
    check_val("s5_count", 32'(viol_count), 0);

    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 59) == 0);
      v = ($urandom_range(0, 5) == 0) ? 6'($urandom_range(1, 63)) : 6'h00;
      p = ($urandom_range(0, 3) == 0) ? RH : PC_X;
      c = ($urandom_range(0, 7) == 0);
      step(r, v, p, c);
    end

    // saturation on a 2-bit counter
    @(posedge clk); #1;
    s_reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      s_viol = 6'h01;
      sat_q.push_back((k + 1 > 3) ? 3 : k + 1);
      @(posedge clk); #1;
      check_val("sat_count", 32'(s_count), 32'(sat_q.pop_front()));
      s_viol = 6'h00;
      repeat (6) @(posedge clk);
      #1;
    end
    check_val("sat_idle",  32'(s_busy), 0);
    check_val("sat_cause", 32'(s_cause), 32'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
